// File: rtl/clk_rst_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and domain index type.
package clk_rst_pkg;

  localparam int MAX_DOM   = 32;
  localparam int DOM_IDX_W = $clog2(MAX_DOM);

  typedef logic [DOM_IDX_W-1:0] dom_idx_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SEQ  = 2'd1,
    DONE = 2'd2
  } rst_seq_state_e;

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter shared by the hold phase and every release slot.
// It stops at zero instead of wrapping, so a slot never runs longer than its load value.
module rst_seq_cnt #(
  parameter int              CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all domain resets for a fixed time, then releases the
// domains one at a time in index order, each after its own programmable delay.
module rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int N_DOM    = 32,
  parameter int CNT_W    = 16,
  parameter int HOLD_CYC = 4,
  parameter int DLY_DEF  = 0,
  localparam int IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_req,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_dly,
  input  logic             cfg_en,
  output logic             cfg_err,
  output logic [N_DOM-1:0] rst_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_RST = CNT_W'(DLY_DEF);

  rst_seq_state_e   state, nxt_state;
  dom_idx_t         idx, nxt_idx;
  logic             last;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             rel_slot;

  logic [CNT_W-1:0] dly [N_DOM];
  logic [N_DOM-1:0] en;

  assign nxt_idx = idx + dom_idx_t'(1);
  assign last    = (int'(idx) == N_DOM - 1);

  rst_seq_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (HOLD_LD)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HOLD;
    end else begin
      state <= nxt_state;
    end
  end

  // Next-state: a software restart overrides everything; otherwise advance on counter expiry.
  always_comb begin
    nxt_state = state;
    if (sw_req) begin
      nxt_state = HOLD;
    end else begin
      case (state)
        HOLD:    if (cnt_zero) nxt_state = SEQ;
        SEQ:     if (cnt_zero && last) nxt_state = DONE;
        DONE:    nxt_state = DONE;
        default: nxt_state = HOLD;
      endcase
    end
  end

  // FSM outputs: counter load strobe/value and the end-of-slot release strobe.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = HOLD_LD;
    rel_slot = 1'b0;
    if (sw_req) begin
      cnt_load = 1'b1;
      cnt_val  = HOLD_LD;
    end else begin
      case (state)
        HOLD: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = dly[0];
          end
        end
        SEQ: begin
          if (cnt_zero) begin
            rel_slot = 1'b1;
            if (!last) begin
              cnt_load = 1'b1;
              cnt_val  = dly[nxt_idx];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Slot index, reset bus and status flags; a disabled domain uses its slot but stays in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      rst_out <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (sw_req) begin
      idx     <= '0;
      rst_out <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (state == HOLD && cnt_zero) begin
      idx <= '0;
    end else if (rel_slot) begin
      if (en[idx]) begin
        rst_out[idx] <= 1'b0;
      end
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        idx <= nxt_idx;
      end
    end
  end

  // Config registers: writes land only while idle and in range, otherwise flag a one-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
      en      <= '1;
      for (int i = 0; i < N_DOM; i++) begin
        dly[i] <= DLY_RST;
      end
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (busy || int'(cfg_idx) >= N_DOM) begin
          cfg_err <= 1'b1;
        end else begin
          dly[cfg_idx] <= cfg_dly;
          en[cfg_idx]  <= cfg_en;
        end
      end
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomized self-checking bench for rst_sequencer against a slot-timing model.
module tb_rst_sequencer;

  localparam int N_DOM    = 32;
  localparam int CNT_W    = 16;
  localparam int HOLD_CYC = 4;
  localparam int DLY_DEF  = 0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sw_req = 1'b0;
  logic             cfg_we = 1'b0;
  logic [4:0]       cfg_idx = '0;
  logic [CNT_W-1:0] cfg_dly = '0;
  logic             cfg_en = 1'b1;
  logic             cfg_err;
  logic [N_DOM-1:0] rst_out;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  // Reference model: configured delays/enables and derived release edges.
  int m_dly [N_DOM];
  bit m_en  [N_DOM];
  int fall  [N_DOM];

  rst_sequencer #(
    .N_DOM    (N_DOM),
    .CNT_W    (CNT_W),
    .HOLD_CYC (HOLD_CYC),
    .DLY_DEF  (DLY_DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_req  (sw_req),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_dly (cfg_dly),
    .cfg_en  (cfg_en),
    .cfg_err (cfg_err),
    .rst_out (rst_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Release edge of domain i, counted from the start edge: HOLD_CYC + sum_{k<=i}(dly[k]+1).
  function automatic int plan();
    int t = HOLD_CYC;
    for (int i = 0; i < N_DOM; i++) begin
      t += m_dly[i] + 1;
      fall[i] = t;
    end
    return t;
  endfunction

  function automatic logic [N_DOM-1:0] exp_vec(int n);
    logic [N_DOM-1:0] v;
    for (int i = 0; i < N_DOM; i++) v[i] = !(m_en[i] && n >= fall[i]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_DOM; i++) begin
      m_dly[i] = DLY_DEF;
      m_en[i]  = 1'b1;
    end
  endfunction

  // Idle-time config write; the model follows because the DUT is not busy.
  task automatic cfg_write(input int idx, input int d, input bit e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 5'(idx); cfg_dly = CNT_W'(d); cfg_en = e;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_dly[idx] = d;
    m_en[idx]  = e;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rst_out !== '1 || busy !== 1'b1 || done !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: rst_out=%h busy=%b done=%b cfg_err=%b, expected ffffffff 1 0 0",
               rst_out, busy, done, cfg_err);
    end
  endtask

  task automatic test_power_on();
    int dt;
    dt = plan();
    @(negedge clk); rst = 1'b0;
    for (int n = 1; n <= dt + 3; n++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_out !== exp_vec(n) || busy !== (n < dt) || done !== (n >= dt)) begin
        errors++;
        $display("FAIL power_on edge %0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                 n, rst_out, busy, done, exp_vec(n), n < dt, n >= dt);
      end
    end
  endtask

  task automatic test_program_delays();
    int dt;
    cfg_write(0, 3, 1'b1);
    cfg_write(1, 0, 1'b1);
    cfg_write(2, 10, 1'b1);
    dt = plan();
    checks++;
    if (fall[0] != 8 || fall[1] != 9 || fall[2] != 20 || fall[3] != 21) begin
      errors++;
      $display("FAIL delay_plan: got %0d %0d %0d %0d, expected 8 9 20 21",
               fall[0], fall[1], fall[2], fall[3]);
    end
    @(negedge clk); sw_req = 1'b1;
    for (int n = 0; n <= dt + 3; n++) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
      checks++;
      if (rst_out !== exp_vec(n) || busy !== (n < dt) || done !== (n >= dt)) begin
        errors++;
        $display("FAIL prog_delays edge %0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                 n, rst_out, busy, done, exp_vec(n), n < dt, n >= dt);
      end
    end
  endtask

  task automatic test_disabled();
    int dt;
    cfg_write(5, m_dly[5], 1'b0);
    dt = plan();
    @(negedge clk); sw_req = 1'b1;
    for (int n = 0; n <= dt + 4; n++) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
      checks++;
      if (rst_out !== exp_vec(n) || busy !== (n < dt) || done !== (n >= dt)) begin
        errors++;
        $display("FAIL disabled edge %0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                 n, rst_out, busy, done, exp_vec(n), n < dt, n >= dt);
      end
    end
    cfg_write(5, m_dly[5], 1'b1);
  endtask

  task automatic test_restart_mid();
    int dt;
    dt = plan();
    @(negedge clk); sw_req = 1'b1;
    for (int n = 0; n < fall[10]; n++) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
      checks++;
      if (rst_out !== exp_vec(n) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL restart_pre edge %0d: rst_out=%h busy=%b done=%b, expected %h 1 0",
                 n, rst_out, busy, done, exp_vec(n));
      end
    end
    // Sequencer now sits in domain 10's slot; restart it from here.
    sw_req = 1'b1;
    for (int n = 0; n <= dt + 2; n++) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
      checks++;
      if (rst_out !== exp_vec(n) || busy !== (n < dt) || done !== (n >= dt)) begin
        errors++;
        $display("FAIL restart_mid edge %0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                 n, rst_out, busy, done, exp_vec(n), n < dt, n >= dt);
      end
    end
  endtask

  task automatic test_cfg_busy();
    int dt;
    int k;
    dt = plan();
    @(negedge clk); sw_req = 1'b1;
    repeat (7) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
    end
    cfg_we = 1'b1; cfg_idx = 5'd2; cfg_dly = CNT_W'(7); cfg_en = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_pulse: cfg_err=%b, expected 1", cfg_err);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_clear: cfg_err=%b, expected 0", cfg_err);
    end
    k = 0;
    while (done !== 1'b1 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL cfg_busy_done: done=%b after %0d cycles, expected 1", done, k);
    end
    // Dropped write must leave domain 2's slot untouched.
    @(negedge clk); sw_req = 1'b1;
    for (int n = 0; n <= dt + 1; n++) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
      checks++;
      if (rst_out !== exp_vec(n) || busy !== (n < dt) || done !== (n >= dt)) begin
        errors++;
        $display("FAIL cfg_busy_seq edge %0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                 n, rst_out, busy, done, exp_vec(n), n < dt, n >= dt);
      end
    end
  endtask

  task automatic test_cfg_with_sw();
    int dt;
    int old_slot;
    old_slot = fall[2] - fall[1];
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 5'd2; cfg_dly = CNT_W'(7); cfg_en = 1'b1;
    sw_req = 1'b1;
    m_dly[2] = 7;
    dt = plan();
    @(posedge clk); #1;
    cfg_we = 1'b0; sw_req = 1'b0;
    checks++;
    if (cfg_err !== 1'b0 || rst_out !== '1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cfg_sw_edge: cfg_err=%b rst_out=%h busy=%b, expected 0 ffffffff 1",
               cfg_err, rst_out, busy);
    end
    checks++;
    if (fall[2] - fall[1] != 8 || old_slot == 8) begin
      errors++;
      $display("FAIL cfg_sw_slot: slot=%0d (old %0d), expected 8", fall[2] - fall[1], old_slot);
    end
    for (int n = 1; n <= dt + 1; n++) begin
      @(posedge clk); #1;
      checks++;
      if (rst_out !== exp_vec(n) || busy !== (n < dt) || done !== (n >= dt)) begin
        errors++;
        $display("FAIL cfg_sw_seq edge %0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                 n, rst_out, busy, done, exp_vec(n), n < dt, n >= dt);
      end
    end
  endtask

  task automatic test_random();
    int dt;
    for (int i = 0; i < N_DOM; i++) begin
      cfg_write(i, int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end
    dt = plan();
    @(negedge clk); sw_req = 1'b1;
    for (int n = 0; n <= dt + 3; n++) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
      checks++;
      if (rst_out !== exp_vec(n) || busy !== (n < dt) || done !== (n >= dt)) begin
        errors++;
        $display("FAIL random edge %0d: rst_out=%h busy=%b done=%b, expected %h %b %b",
                 n, rst_out, busy, done, exp_vec(n), n < dt, n >= dt);
      end
    end
  endtask

  task automatic test_async_reset();
    cfg_write(0, 5, 1'b1);
    cfg_write(3, 2, 1'b0);
    void'(plan());
    @(negedge clk); sw_req = 1'b1;
    repeat (13) begin
      @(posedge clk); #1;
      sw_req = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rst_out !== '1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rst_out=%h busy=%b done=%b, expected ffffffff 1 0",
               rst_out, busy, done);
    end
    model_reset();
    repeat (2) @(posedge clk);
    test_power_on();
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_program_delays();
    test_disabled();
    test_restart_mid();
    test_cfg_busy();
    test_cfg_with_sw();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
